// File: rtl/button_conditioner_if.sv
// Pushbutton conditioner bus: raw button inputs and processor-side controls
// in, conditioned pushbutton value and status flags out.
//   btn_raw       : asynchronous mechanical button inputs, bit i = button i
//   rd_strobe     : processor input-port read enable
//   mode          : 0 = level mode, 1 = sticky-press mode
//   pushbuttons   : registered conditioned value for the processor input port
//   press_pending : OR of all sticky latches
//   overflow      : per-bit sticky flag, a press was lost while still unread
// master drives the inputs (processor / bench side), slave is the conditioner.
interface button_conditioner_if;
    logic [3:0] btn_raw;
    logic       rd_strobe;
    logic       mode;
    logic [3:0] pushbuttons;
    logic       press_pending;
    logic [3:0] overflow;

    modport master (
        output btn_raw,
        output rd_strobe,
        output mode,
        input  pushbuttons,
        input  press_pending,
        input  overflow
    );

    modport slave (
        input  btn_raw,
        input  rd_strobe,
        input  mode,
        output pushbuttons,
        output press_pending,
        output overflow
    );
endinterface

// File: rtl/button_conditioner.sv
// Four-button conditioner: per-bit 2-flop synchronizer, per-bit debounce FSM
// with an 8-bit stable-sample counter, and either a level view or a sticky
// press latch (with lost-press overflow) presented to the processor.
//   clk0   : single clock, all state updates on its rising edge
//   reset0 : asynchronous active-low reset
//   bus    : button_conditioner_if.slave (btn_raw, rd_strobe, mode in;
//            pushbuttons, press_pending, overflow out)
// DEBOUNCE_CYC : stable samples needed to accept a level change (1..255).
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input logic                  clk0,
    input logic                  reset0,
    button_conditioner_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdleLow  = 2'b00,
        StWaitHigh = 2'b01,
        StIdleHigh = 2'b10,
        StWaitLow  = 2'b11
    } state_e;

    localparam logic [7:0] CntMax = 8'(DEBOUNCE_CYC - 1);

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    state_e     state_q [4];
    logic [7:0] cnt_q   [4];

    logic [3:0] deb;
    logic [3:0] press;

    logic       mode_q;
    logic       mode_chg;
    logic [3:0] latch_d, latch_q;
    logic [3:0] ovf_d, ovf_q;
    logic [3:0] pb_d, pb_q;

    // Synchronizers and debounce FSMs. A bounce during WAIT_x drops straight
    // back to the previous idle state, so partial counts never survive.
    always_ff @(posedge clk0 or negedge reset0) begin
        if (!reset0) begin
            sync1_q <= '0;
            sync2_q <= '0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= StIdleLow;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                case (state_q[i])
                    StIdleLow: begin
                        if (sync2_q[i]) begin
                            state_q[i] <= StWaitHigh;
                            cnt_q[i]   <= '0;
                        end
                    end
                    StWaitHigh: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= StIdleLow;
                            cnt_q[i]   <= '0;
                        end else if (cnt_q[i] == CntMax) begin
                            state_q[i] <= StIdleHigh;
                            cnt_q[i]   <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 8'd1;
                        end
                    end
                    StIdleHigh: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= StWaitLow;
                            cnt_q[i]   <= '0;
                        end
                    end
                    StWaitLow: begin
                        if (sync2_q[i]) begin
                            state_q[i] <= StIdleHigh;
                            cnt_q[i]   <= '0;
                        end else if (cnt_q[i] == CntMax) begin
                            state_q[i] <= StIdleLow;
                            cnt_q[i]   <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 8'd1;
                        end
                    end
                    default: begin
                        state_q[i] <= StIdleLow;
                        cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Debounced level and press pulse; the pulse fires on the same edge that
    // moves WAIT_HIGH into IDLE_HIGH, so the latch sets alongside it.
    always_comb begin
        deb   = '0;
        press = '0;
        for (int i = 0; i < 4; i++) begin
            deb[i]   = (state_q[i] == StIdleHigh) || (state_q[i] == StWaitLow);
            press[i] = (state_q[i] == StWaitHigh) && sync2_q[i] && (cnt_q[i] == CntMax);
        end
    end

    assign mode_chg = (bus.mode != mode_q);

    // Sticky path: set beats read-clear on the latch; a read always clears
    // overflow. A mode change wipes the processor-facing state for one edge.
    always_comb begin
        latch_d = '0;
        ovf_d   = '0;
        pb_d    = '0;
        if (!mode_chg) begin
            if (mode_q) begin
                latch_d = press | (latch_q & {4{~bus.rd_strobe}});
                ovf_d   = bus.rd_strobe ? 4'b0000 : (ovf_q | (press & latch_q));
                pb_d    = latch_d;
            end else begin
                pb_d = deb;
            end
        end
    end

    always_ff @(posedge clk0 or negedge reset0) begin
        if (!reset0) begin
            mode_q  <= 1'b0;
            latch_q <= '0;
            ovf_q   <= '0;
            pb_q    <= '0;
        end else begin
            mode_q  <= bus.mode;
            latch_q <= latch_d;
            ovf_q   <= ovf_d;
            pb_q    <= pb_d;
        end
    end

    assign bus.pushbuttons   = pb_q;
    assign bus.press_pending = |latch_q;
    assign bus.overflow      = ovf_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYC, default 16, stable-sample count required to accept a level change; legal range 1..255.
REQ-002 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 btn_raw  in  4  asynchronous mechanical button inputs, bit i = button i.
REQ-005 rd_strobe  in  1  processor input-port read enable, the same signal that loads the uP input register.
REQ-006 mode  in  1  0 = level mode, 1 = sticky-press mode.
REQ-007 pushbuttons  out  4  registered conditioned value driven into the uP pushbutton input.
REQ-008 press_pending  out  1  OR of all sticky latches.
REQ-009 overflow  out  4  per-bit sticky flag: a press was lost because it occurred while the previous press was still unread.

Function
REQ-010 Each bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 Each bit SHALL have an independent debounce FSM with states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW, plus an 8-bit counter.
REQ-012 IDLE_LOW with sync=1 SHALL go to WAIT_HIGH with cnt=0; IDLE_HIGH with sync=0 SHALL go to WAIT_LOW with cnt=0.
REQ-013 In WAIT_x, when sync equals the target level, cnt SHALL increment.
- When cnt==DEBOUNCE_CYC-1 and sync still equals the target level, the FSM SHALL enter IDLE_x.
- WAIT_x SHALL NOT be exited on wrap-around: cnt never exceeds DEBOUNCE_CYC-1.
REQ-014 In WAIT_x, sync not equal to the target level SHALL return the FSM to the prior IDLE state with cnt=0; partial counts are never retained.
REQ-015 Debounced bit = 1 in IDLE_HIGH and WAIT_LOW, 0 otherwise.
REQ-016 With btn_raw held steady, the debounced bit SHALL change on rising edge DEBOUNCE_CYC+3, where edge 1 is the first edge sampling the new value.
REQ-017 A press event SHALL be a one-cycle internal pulse on the WAIT_HIGH->IDLE_HIGH transition. Release produces no event.
REQ-018 In sticky mode (mode=1), a press event SHALL set latch[i], and pushbuttons SHALL equal the latch register.
REQ-019 rd_strobe=1 SHALL clear all latches and all overflow bits at the next edge.
- If a press event on bit i coincides with rd_strobe, latch[i] SHALL end at 1 (set wins) and overflow[i] SHALL end at 0.
REQ-020 A press event on bit i while latch[i]=1 and rd_strobe=0 SHALL set overflow[i]; latch[i] stays 1.
REQ-021 In level mode (mode=0), pushbuttons SHALL equal the debounced vector, registered one cycle after it.
- Latches and overflow SHALL be held at 0 in level mode.
REQ-022 Any change of mode SHALL clear latches, overflow and pushbuttons at the next edge. Debounce FSMs are unaffected.
REQ-023 press_pending SHALL be combinational OR of latch[3:0].

Reset
REQ-024 When reset=0, all of the following SHALL clear immediately, independent of clock:
- synchronizer flops, counters, latches, overflow and pushbuttons to 0;
- every FSM to IDLE_LOW.
REQ-025 A reset asserted mid-WAIT SHALL discard the count. After release, a held button SHALL require the full REQ-016 latency again.
REQ-026 While reset=0, outputs SHALL remain 0 regardless of btn_raw, rd_strobe or mode.

Verification (DEBOUNCE_CYC=4)
REQ-027 mode=0, btn_raw=4'b0001 held -> pushbuttons=4'b0001 at edge 8, 0 before; release -> 4'b0000 at edge 8 after release.
REQ-028 Bounce 1,0,1,0 toggling each cycle on bit 2, then held 1 -> no change until edge 7 after the final rise, then bit 2 = 1.
REQ-029 mode=1, press bit 3 -> pushbuttons=4'b1000, press_pending=1; rd_strobe pulse -> 4'b0000 next edge.
REQ-030 mode=1, two presses on bit 0 with no read -> overflow=4'b0001. Press event on the same cycle as rd_strobe -> pushbuttons[0]=1, overflow=0.
REQ-031 Bit 1 held for 3 cycles into WAIT_HIGH, reset pulsed low mid-clock -> outputs 0 immediately; after release, bit 1 rises only after 7 further edges.
REQ-032 Sticky latch=4'b0100, mode toggled to 0 -> pushbuttons and overflow = 0 next edge, then track the debounced level.
